mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one memory port between two requesters: port 0 (instruction fetch) and port 1 (load/store).
//  Round-robin arbitration with a req/ack handshake to each requester and a req/ready handshake to memory.
//  Drives the sel of the shared 2:1 address/wdata mux (DATA_SIZE wide) and returns read data.
//  Sits between the core front-end/LSU and the unified memory in the multi-cycle variant of the CPU.
// PARAMETERS
//  DATA_SIZE  32  width of wdata/rdata buses
//  ADDR_SIZE  32  width of address buses
//  MAX_WAIT   16  max cycles in BUSY without mem_ready before timeout (>=1)
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous, active-high reset
//  req0       in   1          port 0 request; held high until ack0
//  addr0      in   ADDR_SIZE  port 0 address
//  wdata0     in   DATA_SIZE  port 0 write data
//  we0        in   1          port 0 write enable
//  req1/addr1/wdata1/we1      as port 0, for port 1
//  ack0       out  1          one-cycle completion pulse to port 0
//  ack1       out  1          one-cycle completion pulse to port 1
//  err        out  1          valid with ack0/ack1: 1 = transaction timed out
//  rdata      out  DATA_SIZE  read data, valid while ack0/ack1 high
//  sel        out  1          current grant / shared mux select (0 = port 0, 1 = port 1)
//  mem_req    out  1          memory request, high throughout BUSY
//  mem_addr   out  ADDR_SIZE  latched address of granted port
//  mem_wdata  out  DATA_SIZE  latched write data of granted port
//  mem_we     out  1          latched write enable of granted port
//  mem_ready  in   1          memory completion; sampled only in BUSY
//  mem_rdata  in   DATA_SIZE  memory read data, valid with mem_ready
// BEHAVIOUR
//  Reset: state=IDLE, sel=0, last=1 (port 0 wins first tie), ack0=ack1=err=0, rdata=0, mem_req=0, mem_addr/mem_wdata=0, mem_we=0, wait_cnt=0.
//  FSM: IDLE -> BUSY -> RESP -> IDLE.
//  IDLE: if req0|req1 at edge: winner = only requester, or !last if both; sel<=winner;
//    latch addr/wdata/we of winner into mem_addr/mem_wdata/mem_we; wait_cnt<=0; go BUSY.
//  BUSY: mem_req=1, sel and latched fields stable. Requester inputs ignored (changes do not affect transaction).
//    mem_ready=1 at edge: rdata<=mem_rdata (0 on write), err<=0, last<=sel, go RESP.
//    else wait_cnt++; if wait_cnt==MAX_WAIT-1 at edge: rdata<=0, err<=1, last<=sel, go RESP.
//    mem_ready wins over timeout on the same edge.
//  RESP: ack[sel]=1 for exactly this cycle; other ack=0; mem_req=0; next state IDLE.
//  Latency: req seen at edge N -> mem_req high N+1; mem_ready at edge M -> ack high cycle after M. Min req->ack 3 edges.
//  req dropped before ack: transaction still completes and ack still pulses.
//  req still high in IDLE after its ack: treated as a new request (subject to round-robin).
//  mem_ready in IDLE/RESP ignored. rdata/err hold value after RESP until next RESP.
//  rst mid-transaction: abandon immediately, all outputs to reset values next cycle, no ack issued.
//  Write vs read identical in timing; mem_we merely forwarded.
// TESTING
//  1 Single read p0: addr0=32'h0000_0040, mem_ready 2 cycles later with rdata=32'hF486_BCED -> ack0 one cycle, rdata=F486BCED, err=0, sel=0.
//  2 Simultaneous req0/req1 after reset -> p0 first (mem_addr=addr0), then p1 (sel=1, mem_addr=addr1); repeat tie -> p0 again.
//  3 Write p1: we1=1, wdata1=32'h1234_5678 -> mem_we=1, mem_wdata=12345678 during BUSY, ack1 pulse, ack0 stays 0.
//  4 Timeout: req0, mem_ready held 0, MAX_WAIT=16 -> ack0 with err=1, rdata=0 exactly 16 BUSY cycles after grant.
//  5 mem_ready on final timeout cycle -> err=0, rdata=mem_rdata.
//  6 rst asserted in BUSY -> next cycle mem_req=0, sel=0, no ack; following tie grants p0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the two requesters, the round-robin arbiter and the shared memory port.
// The arbiter takes the master side; the requesters and the memory model take the slave side.
interface mem_port_arbiter_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 32
) ();
    logic                 req0;
    logic [ADDR_SIZE-1:0] addr0;
    logic [DATA_SIZE-1:0] wdata0;
    logic                 we0;
    logic                 req1;
    logic [ADDR_SIZE-1:0] addr1;
    logic [DATA_SIZE-1:0] wdata1;
    logic                 we1;
    logic                 ack0;
    logic                 ack1;
    logic                 err;
    logic [DATA_SIZE-1:0] rdata;
    logic                 sel;
    logic                 mem_req;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic                 mem_we;
    logic                 mem_ready;
    logic [DATA_SIZE-1:0] mem_rdata;

    modport master (
        input  req0, addr0, wdata0, we0,
        input  req1, addr1, wdata1, we1,
        input  mem_ready, mem_rdata,
        output ack0, ack1, err, rdata, sel,
        output mem_req, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output req0, addr0, wdata0, we0,
        output req1, addr1, wdata1, we1,
        output mem_ready, mem_rdata,
        input  ack0, ack1, err, rdata, sel,
        input  mem_req, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (port 0) and load/store (port 1).
// Each transaction runs IDLE -> BUSY -> RESP; a BUSY phase that outlasts MAX_WAIT cycles completes with err set.
module mem_port_arbiter #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 32,
    parameter int MAX_WAIT  = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master io_bus
);
    localparam int            CW        = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic                 r_sel;
    logic                 r_last;
    logic                 r_err;
    logic                 r_memWe;
    logic [CW-1:0]        r_waitCnt;
    logic [DATA_SIZE-1:0] r_rdata;
    logic [DATA_SIZE-1:0] r_memWdata;
    logic [ADDR_SIZE-1:0] r_memAddr;
    logic                 w_anyReq;
    logic                 w_winner;
    logic                 w_timeout;
    logic                 w_memReq;
    logic                 w_ack0;
    logic                 w_ack1;

    // On a tie the port that was not served last wins; r_last resets to 1 so port 0 wins the first tie.
    assign w_anyReq  = io_bus.req0 | io_bus.req1;
    assign w_winner  = (io_bus.req0 & io_bus.req1) ? ~r_last : io_bus.req1;
    assign w_timeout = (r_waitCnt == LAST_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_memReq    = 1'b0;
        w_ack0      = 1'b0;
        w_ack1      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                w_memReq = 1'b1;
                if (io_bus.mem_ready || w_timeout) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                w_ack0      = ~r_sel;
                w_ack1      = r_sel;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // A ready on the final wait cycle takes priority, so a late answer is never reported as a timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel      <= 1'b0;
            r_last     <= 1'b1;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_memWe    <= 1'b0;
            r_waitCnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_sel      <= w_winner;
                        r_memAddr  <= w_winner ? io_bus.addr1  : io_bus.addr0;
                        r_memWdata <= w_winner ? io_bus.wdata1 : io_bus.wdata0;
                        r_memWe    <= w_winner ? io_bus.we1    : io_bus.we0;
                        r_waitCnt  <= '0;
                    end
                end
                BUSY: begin
                    if (io_bus.mem_ready) begin
                        r_rdata <= r_memWe ? '0 : io_bus.mem_rdata;
                        r_err   <= 1'b0;
                        r_last  <= r_sel;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_last  <= r_sel;
                    end else begin
                        r_waitCnt <= r_waitCnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bus.ack0      = w_ack0;
    assign io_bus.ack1      = w_ack1;
    assign io_bus.err       = r_err;
    assign io_bus.rdata     = r_rdata;
    assign io_bus.sel       = r_sel;
    assign io_bus.mem_req   = w_memReq;
    assign io_bus.mem_addr  = r_memAddr;
    assign io_bus.mem_wdata = r_memWdata;
    assign io_bus.mem_we    = r_memWe;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized transactions against a transaction-level model of the round-robin arbiter.
// The model predicts the winner, latched fields, completion cycle, rdata and err from the arbitration rules.
module tb_mem_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();

    mem_port_arbiter #(
        .DATA_SIZE(DW),
        .ADDR_SIZE(AW),
        .MAX_WAIT (MW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus)
    );

    int            nChecks = 0;
    int            nPass   = 0;
    logic          mLast;
    logic [DW-1:0] mRdata;
    logic          mErr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic r0, input logic r1, input logic w0, input logic w1,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1);
        bus.req0   = r0;
        bus.req1   = r1;
        bus.we0    = w0;
        bus.we1    = w1;
        bus.addr0  = a0;
        bus.addr1  = a1;
        bus.wdata0 = d0;
        bus.wdata1 = d1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " idle ack0"},    bus.ack0,    0);
        checkOutput({tag, " idle ack1"},    bus.ack1,    0);
        checkOutput({tag, " idle mem_req"}, bus.mem_req, 0);
        checkOutput({tag, " idle rdata"},   bus.rdata,   mRdata);
        checkOutput({tag, " idle err"},     bus.err,     mErr);
    endtask

    // One whole transaction from IDLE with the requester inputs already applied.
    // readyDelay counts BUSY cycles before mem_ready; anything beyond MW-1 means memory never answers.
    task automatic runTxn(input logic hold, input int readyDelay, input logic [31:0] memData, input string tag);
        logic          win;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expWdata;
        logic          expWe;
        logic          timedOut;
        int            busyEdges;
        logic [DW-1:0] expRdata;
        win       = (bus.req0 && bus.req1) ? !mLast : bus.req1;
        expAddr   = win ? bus.addr1  : bus.addr0;
        expWdata  = win ? bus.wdata1 : bus.wdata0;
        expWe     = win ? bus.we1    : bus.we0;
        timedOut  = (readyDelay > MW - 1);
        busyEdges = timedOut ? MW : readyDelay + 1;
        bus.mem_ready = 1'b0;
        tick();
        checkOutput({tag, " grant sel"},  bus.sel,  win);
        checkOutput({tag, " grant ack0"}, bus.ack0, 0);
        checkOutput({tag, " grant ack1"}, bus.ack1, 0);
        checkOutput({tag, " mem_wdata"},  bus.mem_wdata, expWdata);
        checkOutput({tag, " mem_we"},     bus.mem_we,    expWe);
        if (!hold) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end
        bus.addr0  = $urandom;
        bus.addr1  = $urandom;
        bus.wdata0 = $urandom;
        bus.wdata1 = $urandom;
        for (int k = 0; k < busyEdges; k++) begin
            checkOutput({tag, " busy mem_req"},  bus.mem_req,  1);
            checkOutput({tag, " busy mem_addr"}, bus.mem_addr, expAddr);
            bus.mem_ready = (k == readyDelay);
            bus.mem_rdata = (k == readyDelay) ? memData : DW'($urandom);
            tick();
        end
        expRdata = (timedOut || expWe) ? '0 : memData;
        checkOutput({tag, " resp ack0"},    bus.ack0,    !win);
        checkOutput({tag, " resp ack1"},    bus.ack1,    win);
        checkOutput({tag, " resp mem_req"}, bus.mem_req, 0);
        checkOutput({tag, " resp rdata"},   bus.rdata,   expRdata);
        checkOutput({tag, " resp err"},     bus.err,     timedOut);
        checkOutput({tag, " resp sel"},     bus.sel,     win);
        mLast  = win;
        mRdata = expRdata;
        mErr   = timedOut;
        bus.mem_ready = 1'($urandom);
        bus.mem_rdata = $urandom;
        tick();
        checkIdleOutputs(tag);
        bus.mem_ready = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.mem_ready = 1'($urandom);
            bus.mem_rdata = $urandom;
            tick();
            checkIdleOutputs("idle");
        end
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        mLast  = 1'b1;
        mRdata = '0;
        mErr   = 1'b0;
        rst    = 1'b1;
        tick();
        tick();
        checkOutput("reset sel",       bus.sel,       0);
        checkOutput("reset ack0",      bus.ack0,      0);
        checkOutput("reset ack1",      bus.ack1,      0);
        checkOutput("reset err",       bus.err,       0);
        checkOutput("reset rdata",     bus.rdata,     0);
        checkOutput("reset mem_req",   bus.mem_req,   0);
        checkOutput("reset mem_addr",  bus.mem_addr,  0);
        checkOutput("reset mem_wdata", bus.mem_wdata, 0);
        checkOutput("reset mem_we",    bus.mem_we,    0);
        rst = 1'b0;
        idleCycles(2);

        // Held ties alternate p0, p1, p0.
        applyStimulus(1, 1, 0, 0, 32'h0000_0100, 32'h0000_0200, 0, 0);
        runTxn(1, 1, 32'hAAAA_0001, "tie1");
        applyStimulus(1, 1, 0, 0, 32'h0000_0104, 32'h0000_0204, 0, 0);
        runTxn(1, 0, 32'hAAAA_0002, "tie2");
        applyStimulus(1, 1, 0, 0, 32'h0000_0108, 32'h0000_0208, 0, 0);
        runTxn(0, 2, 32'hAAAA_0003, "tie3");

        applyStimulus(1, 0, 0, 0, 32'h0000_0040, $urandom, $urandom, $urandom);
        runTxn(0, 2, 32'hF486_BCED, "read_p0");

        applyStimulus(0, 1, 0, 1, $urandom, 32'h0000_00A0, $urandom, 32'h1234_5678);
        runTxn(0, 3, 32'hDEAD_BEEF, "write_p1");

        applyStimulus(1, 0, 0, 0, 32'h0000_0300, $urandom, $urandom, $urandom);
        runTxn(0, 1000, 32'h5555_5555, "timeout");

        applyStimulus(1, 0, 0, 0, 32'h0000_0304, $urandom, $urandom, $urandom);
        runTxn(0, MW - 1, 32'hCAFE_F00D, "late_ready");

        // Reset in the middle of BUSY abandons the transaction without an ack.
        applyStimulus(1, 1, 0, 1, 32'h0000_0400, 32'h0000_0500, 32'h1111_1111, 32'h2222_2222);
        tick();
        checkOutput("rst busy mem_req", bus.mem_req, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mLast  = 1'b1;
        mRdata = '0;
        mErr   = 1'b0;
        checkOutput("rst mem_req",   bus.mem_req,   0);
        checkOutput("rst sel",       bus.sel,       0);
        checkOutput("rst ack0",      bus.ack0,      0);
        checkOutput("rst ack1",      bus.ack1,      0);
        checkOutput("rst mem_addr",  bus.mem_addr,  0);
        checkOutput("rst mem_we",    bus.mem_we,    0);
        checkOutput("rst err",       bus.err,       0);
        applyStimulus(1, 1, 0, 0, 32'h0000_0600, 32'h0000_0700, 0, 0);
        runTxn(0, 0, 32'h7777_7777, "post_rst_tie");

        for (int n = 0; n < 40; n++) begin
            int            reqs;
            int            delay;
            logic [31:0]   a0;
            logic [31:0]   a1;
            logic [31:0]   d0;
            logic [31:0]   d1;
            reqs  = $urandom_range(1, 3);
            delay = ($urandom_range(0, 9) < 2) ? $urandom_range(MW - 2, MW + 2) : $urandom_range(0, 4);
            a0 = $urandom;
            a1 = $urandom;
            d0 = $urandom;
            d1 = $urandom;
            applyStimulus(reqs[0], reqs[1], 1'($urandom), 1'($urandom), a0, a1, d0, d1);
            runTxn(1'($urandom), delay, $urandom, "rand");
            idleCycles($urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
